// File: rtl/elec_cfg_pkg.sv
// Shared definitions for the electrode-configuration deserializer.
// Contents:
//   state_e   - FSM state encoding (IDLE / SHIFT / HALT)
//   SAFE_LEVEL - per-electrode drive level used for the safe (all-off) state
//   cnt_width - bit-counter width for a given electrode count; the counter
//               must hold N+1 so that overlong frames can be detected
package elec_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic SAFE_LEVEL = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned n_elec);
    return $clog2(n_elec + 2);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-stage flip-flop synchronizer for one inter-FPGA input bit.
// Ports:
//   clock - system clock
//   rst   - synchronous active-high reset, clears all stages
//   d     - asynchronous/inter-FPGA input
//   q     - synchronized output, STAGES cycles after d
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/elec_config_deserializer.sv
// Receives the serial electrode configuration from FPGA1, validates frame
// length, holds a good frame in a shadow register and applies it to the
// electrode drive outputs on each step command.
// Ports:
//   clock, rst     - system clock, synchronous active-high reset
//   serial_in      - serial electrode data, MSB (electrode N-1) first
//   enable_config  - frame enable, high while serial_in is valid
//   next_sequence  - step command, rising edge applies the pending frame
//   stop_fpga2     - level, high forces all electrodes off (HALT)
//   elec_active    - applied electrode drive pattern
//   cfg_pending    - a good frame is held and not yet applied
//   frame_ok / frame_err / seq_miss / applied - one-cycle event pulses
//   seq_count      - number of applied steps, wrapping
//   halted         - high while in HALT
module elec_config_deserializer
  import elec_cfg_pkg::*;
#(
  parameter int unsigned N_ELECTRODES = 129,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SEQ_CNT_W    = 8
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    serial_in,
  input  logic                    enable_config,
  input  logic                    next_sequence,
  input  logic                    stop_fpga2,
  output logic [N_ELECTRODES-1:0] elec_active,
  output logic                    cfg_pending,
  output logic                    frame_ok,
  output logic                    frame_err,
  output logic                    seq_miss,
  output logic                    applied,
  output logic [SEQ_CNT_W-1:0]    seq_count,
  output logic                    halted
);

  localparam int unsigned CNT_W = cnt_width(N_ELECTRODES);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_ELECTRODES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(N_ELECTRODES + 1);

  logic data_s, en_s, nseq_s, stop_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_data (.clock(clock), .rst(rst), .d(serial_in),     .q(data_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_en   (.clock(clock), .rst(rst), .d(enable_config), .q(en_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_nseq (.clock(clock), .rst(rst), .d(next_sequence), .q(nseq_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_stop (.clock(clock), .rst(rst), .d(stop_fpga2),    .q(stop_s));

  state_e                  state_q, state_d;
  logic [N_ELECTRODES-1:0] shift_q, shift_d;
  logic [N_ELECTRODES-1:0] shadow_q, shadow_d;
  logic [N_ELECTRODES-1:0] active_q, active_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SEQ_CNT_W-1:0]    seq_cnt_q, seq_cnt_d;
  logic pending_q, pending_d;
  logic en_prev_q, en_prev_d;
  logic nseq_prev_q, nseq_prev_d;
  logic nseq_rise_q, nseq_rise_d;
  logic frame_ok_q, frame_ok_d;
  logic frame_err_q, frame_err_d;
  logic seq_miss_q, seq_miss_d;
  logic applied_q, applied_d;
  logic halted_q, halted_d;

  logic en_rise;

  assign en_rise = en_s & ~en_prev_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    cnt_d       = cnt_q;
    seq_cnt_d   = seq_cnt_q;
    pending_d   = pending_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    seq_miss_d  = 1'b0;
    applied_d   = 1'b0;
    en_prev_d   = en_s;
    nseq_prev_d = nseq_s;
    // Step edge is registered once more so the apply stage sees a clean pulse.
    nseq_rise_d = nseq_s & ~nseq_prev_q;

    if (stop_s) begin
      state_d   = ST_HALT;
      active_d  = {N_ELECTRODES{SAFE_LEVEL}};
      pending_d = 1'b0;
      cnt_d     = '0;
    end else begin
      // Apply is evaluated first so it uses the pre-cycle shadow/pending;
      // a frame completing in the same cycle then overrides pending below.
      if (state_q != ST_HALT && nseq_rise_q) begin
        if (pending_q) begin
          active_d  = shadow_q;
          pending_d = 1'b0;
          applied_d = 1'b1;
          seq_cnt_d = seq_cnt_q + SEQ_CNT_W'(1);
        end else begin
          seq_miss_d = 1'b1;
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (en_rise) begin
            shift_d = {shift_q[N_ELECTRODES-2:0], data_s};
            cnt_d   = CNT_W'(1);
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (en_s) begin
            shift_d = {shift_q[N_ELECTRODES-2:0], data_s};
            if (cnt_q != CNT_SAT) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            if (cnt_q == CNT_FULL) begin
              shadow_d   = shift_q;
              pending_d  = 1'b1;
              frame_ok_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_HALT: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      cnt_q       <= '0;
      seq_cnt_q   <= '0;
      pending_q   <= 1'b0;
      en_prev_q   <= 1'b0;
      nseq_prev_q <= 1'b0;
      nseq_rise_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      seq_miss_q  <= 1'b0;
      applied_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      seq_cnt_q   <= seq_cnt_d;
      pending_q   <= pending_d;
      en_prev_q   <= en_prev_d;
      nseq_prev_q <= nseq_prev_d;
      nseq_rise_q <= nseq_rise_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      seq_miss_q  <= seq_miss_d;
      applied_q   <= applied_d;
      halted_q    <= halted_d;
    end
  end

  assign elec_active = active_q;
  assign cfg_pending = pending_q;
  assign frame_ok    = frame_ok_q;
  assign frame_err   = frame_err_q;
  assign seq_miss    = seq_miss_q;
  assign applied     = applied_q;
  assign seq_count   = seq_cnt_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_elec_config_deserializer.sv
module tb_elec_config_deserializer;

  localparam int N  = 129;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          rst;
  logic          serial_in;
  logic          enable_config;
  logic          next_sequence;
  logic          stop_fpga2;
  logic [N-1:0]  elec_active;
  logic          cfg_pending;
  logic          frame_ok;
  logic          frame_err;
  logic          seq_miss;
  logic          applied;
  logic [CW-1:0] seq_count;
  logic          halted;

  elec_config_deserializer #(
    .N_ELECTRODES(N),
    .SYNC_STAGES (2),
    .SEQ_CNT_W   (CW)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .serial_in    (serial_in),
    .enable_config(enable_config),
    .next_sequence(next_sequence),
    .stop_fpga2   (stop_fpga2),
    .elec_active  (elec_active),
    .cfg_pending  (cfg_pending),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .seq_miss     (seq_miss),
    .applied      (applied),
    .seq_count    (seq_count),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0]  active;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int vectors     = 0;
  int miscompares = 0;
  int ok_cnt      = 0;
  int err_cnt     = 0;
  int miss_cnt    = 0;
  int app_cnt     = 0;

  logic [N-1:0]  model_active;
  logic [N-1:0]  model_shadow;
  logic          model_pending;
  logic [CW-1:0] model_cnt;

  // Event monitor and scoreboard: every applied pulse must match the
  // oldest expected pattern/count pushed by the stimulus side.
  always @(negedge clock) begin
    if (!rst) begin
      if (frame_ok)  ok_cnt++;
      if (frame_err) err_cnt++;
      if (seq_miss)  miss_cnt++;
      if (applied) begin
        app_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL apply_unexpected: elec_active=%h seq_count=%0d, required no apply", elec_active, seq_count);
        end else begin
          mon_e = exp_q.pop_front();
          if (elec_active !== mon_e.active || seq_count !== mon_e.cnt) begin
            miscompares++;
            $display("FAIL apply_value: elec_active=%h seq_count=%0d, required %h / %0d",
                     elec_active, seq_count, mon_e.active, mon_e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    serial_in = 1'b0;
    enable_config = 1'b0;
    next_sequence = 1'b0;
    stop_fpga2 = 1'b0;
    tick(1);
    exp_q.delete();
    model_active  = '0;
    model_shadow  = '0;
    model_pending = 1'b0;
    model_cnt     = '0;
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input logic [N+1:0] data, input int len, input int stop_at, input bit nseq_last);
    for (int i = 0; i < len; i++) begin
      serial_in = data[len-1-i];
      enable_config = 1'b1;
      if (i == stop_at) stop_fpga2 = 1'b1;
      if (nseq_last && i == len - 1) next_sequence = 1'b1;
      tick(1);
    end
    enable_config = 1'b0;
    serial_in = 1'b0;
    next_sequence = 1'b0;
  endtask

  // Model side of a step command, then drive the pulse.
  task automatic apply_step;
    exp_t e;
    if (model_pending) begin
      model_cnt     = model_cnt + 1'b1;
      model_active  = model_shadow;
      model_pending = 1'b0;
      e.active = model_active;
      e.cnt    = model_cnt;
      exp_q.push_back(e);
    end
    next_sequence = 1'b1;
    tick(1);
    next_sequence = 1'b0;
    tick(6);
  endtask

  function automatic logic [N+1:0] alt_pattern();
    logic [N+1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[k] = ~k[0];
    return p;
  endfunction

  function automatic logic [N+1:0] rand_pattern();
    logic [N+1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[k] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    serial_in = 1'b0;
    enable_config = 1'b0;
    next_sequence = 1'b0;
    stop_fpga2 = 1'b0;
    tick(2);
    vectors++;
    if ({elec_active, cfg_pending, frame_ok, frame_err, seq_miss, applied, seq_count, halted} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: elec_active=%h pend=%b ok=%b err=%b miss=%b app=%b cnt=%0d halt=%b, required all 0",
               elec_active, cfg_pending, frame_ok, frame_err, seq_miss, applied, seq_count, halted);
    end
    do_reset();
  endtask

  task automatic test_basic;
    logic [N+1:0] pat;
    exp_t e;
    pat = alt_pattern();
    send_frame(pat, N, -1, 1'b0);
    tick(2);
    vectors++;
    if (frame_ok !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_ok_early: frame_ok=%b, required 0", frame_ok);
    end
    tick(1);
    vectors++;
    if (frame_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_ok_latency: frame_ok=%b, required 1", frame_ok);
    end
    tick(1);
    vectors++;
    if (frame_ok !== 1'b0 || cfg_pending !== 1'b1 || elec_active !== '0) begin
      miscompares++;
      $display("FAIL frame_capture: ok=%b pend=%b active=%h, required 0/1/0", frame_ok, cfg_pending, elec_active);
    end
    model_shadow = pat[N-1:0];
    model_pending = 1'b1;
    model_cnt = model_cnt + 1'b1;
    model_active = model_shadow;
    model_pending = 1'b0;
    e.active = model_active;
    e.cnt = model_cnt;
    exp_q.push_back(e);
    next_sequence = 1'b1;
    tick(1);
    next_sequence = 1'b0;
    tick(2);
    vectors++;
    if (applied !== 1'b0 || elec_active !== '0) begin
      miscompares++;
      $display("FAIL apply_early: applied=%b active=%h, required 0/0", applied, elec_active);
    end
    tick(1);
    vectors++;
    if (applied !== 1'b1 || elec_active[N-1] !== 1'b1 || elec_active[N-2] !== 1'b0 || elec_active[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL apply_latency: applied=%b active=%h, required 1 / %h", applied, elec_active, pat[N-1:0]);
    end
    tick(4);
    vectors++;
    if (cfg_pending !== 1'b0 || seq_count !== 8'd1) begin
      miscompares++;
      $display("FAIL after_apply: pend=%b cnt=%0d, required 0/1", cfg_pending, seq_count);
    end
  endtask

  task automatic test_bad_length;
    int err0;
    do_reset();
    err0 = err_cnt;
    send_frame(alt_pattern(), N - 1, -1, 1'b0);
    tick(6);
    send_frame(rand_pattern() | {2'b11, {N{1'b0}}}, N + 1, -1, 1'b0);
    tick(6);
    vectors++;
    if (err_cnt - err0 !== 2 || cfg_pending !== 1'b0 || elec_active !== '0) begin
      miscompares++;
      $display("FAIL bad_length: errs=%0d pend=%b active=%h, required 2/0/0", err_cnt - err0, cfg_pending, elec_active);
    end
  endtask

  task automatic test_seq_miss;
    int miss0, app0;
    miss0 = miss_cnt;
    app0 = app_cnt;
    apply_step();
    vectors++;
    if (miss_cnt - miss0 !== 1 || app_cnt !== app0 || elec_active !== model_active || seq_count !== model_cnt) begin
      miscompares++;
      $display("FAIL seq_miss: misses=%0d applies=%0d active=%h cnt=%0d, required 1/0/%h/%0d",
               miss_cnt - miss0, app_cnt - app0, elec_active, seq_count, model_active, model_cnt);
    end
  endtask

  task automatic test_halt;
    logic [N+1:0] fa, fb, fd;
    int err0, ok0, miss0, app0;
    do_reset();
    fa = rand_pattern();
    fb = rand_pattern();
    fd = rand_pattern();
    send_frame(fa, N, -1, 1'b0);
    tick(6);
    model_shadow = fa[N-1:0]; model_pending = 1'b1;
    apply_step();
    send_frame(fb, N, -1, 1'b0);
    tick(6);
    model_shadow = fb[N-1:0]; model_pending = 1'b1;
    err0 = err_cnt; ok0 = ok_cnt;
    send_frame(rand_pattern(), N, 50, 1'b0);
    tick(4);
    model_pending = 1'b0;
    model_active = '0;
    vectors++;
    if (elec_active !== '0 || halted !== 1'b1 || cfg_pending !== 1'b0 || err_cnt !== err0 || ok_cnt !== ok0) begin
      miscompares++;
      $display("FAIL halt_state: active=%h halted=%b pend=%b errs=%0d oks=%0d, required 0/1/0/0/0",
               elec_active, halted, cfg_pending, err_cnt - err0, ok_cnt - ok0);
    end
    miss0 = miss_cnt; app0 = app_cnt;
    next_sequence = 1'b1;
    tick(1);
    next_sequence = 1'b0;
    tick(6);
    vectors++;
    if (miss_cnt !== miss0 || app_cnt !== app0 || elec_active !== '0) begin
      miscompares++;
      $display("FAIL halt_step_ignored: misses=%0d applies=%0d active=%h, required 0/0/0",
               miss_cnt - miss0, app_cnt - app0, elec_active);
    end
    stop_fpga2 = 1'b0;
    tick(5);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_release: halted=%b, required 0", halted);
    end
    send_frame(fd, N, -1, 1'b0);
    tick(6);
    model_shadow = fd[N-1:0]; model_pending = 1'b1;
    apply_step();
    vectors++;
    if (elec_active !== fd[N-1:0] || seq_count !== model_cnt || cfg_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL post_halt_apply: active=%h cnt=%0d pend=%b, required %h/%0d/0",
               elec_active, seq_count, cfg_pending, fd[N-1:0], model_cnt);
    end
  endtask

  task automatic test_simultaneous;
    logic [N+1:0] fa, fb;
    exp_t e;
    int ok0, miss0, app0;
    // Nothing pending: the coincident step misses and the new frame stays.
    do_reset();
    fb = rand_pattern();
    miss0 = miss_cnt;
    send_frame(fb, N, -1, 1'b1);
    tick(6);
    vectors++;
    if (miss_cnt - miss0 !== 1 || cfg_pending !== 1'b1 || elec_active !== '0) begin
      miscompares++;
      $display("FAIL simul_empty: misses=%0d pend=%b active=%h, required 1/1/0", miss_cnt - miss0, cfg_pending, elec_active);
    end
    // Frame A pending: A is applied, B becomes pending.
    do_reset();
    fa = rand_pattern();
    fb = rand_pattern();
    send_frame(fa, N, -1, 1'b0);
    tick(6);
    ok0 = ok_cnt; app0 = app_cnt; miss0 = miss_cnt;
    model_cnt = model_cnt + 1'b1;
    e.active = fa[N-1:0];
    e.cnt = model_cnt;
    exp_q.push_back(e);
    send_frame(fb, N, -1, 1'b1);
    tick(6);
    model_active = fa[N-1:0];
    model_shadow = fb[N-1:0];
    model_pending = 1'b1;
    vectors++;
    if (elec_active !== fa[N-1:0] || cfg_pending !== 1'b1 || ok_cnt - ok0 !== 1 || app_cnt - app0 !== 1 || miss_cnt !== miss0) begin
      miscompares++;
      $display("FAIL simul_pending: active=%h pend=%b oks=%0d applies=%0d misses=%0d, required %h/1/1/1/0",
               elec_active, cfg_pending, ok_cnt - ok0, app_cnt - app0, miss_cnt - miss0, fa[N-1:0]);
    end
    apply_step();
    vectors++;
    if (elec_active !== fb[N-1:0] || seq_count !== 8'd2 || cfg_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_second: active=%h cnt=%0d pend=%b, required %h/2/0", elec_active, seq_count, cfg_pending, fb[N-1:0]);
    end
  endtask

  task automatic test_wrap_and_reset;
    logic [N+1:0] f;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      f = rand_pattern();
      send_frame(f, N, -1, 1'b0);
      tick(6);
      model_shadow = f[N-1:0];
      model_pending = 1'b1;
      apply_step();
    end
    vectors++;
    if (seq_count !== 8'd0) begin
      miscompares++;
      $display("FAIL seq_wrap: seq_count=%0d, required 0", seq_count);
    end
    f = rand_pattern() | 1;
    send_frame(f, N, -1, 1'b0);
    tick(6);
    model_shadow = f[N-1:0];
    model_pending = 1'b1;
    apply_step();
    vectors++;
    if (seq_count !== 8'd1 || elec_active !== f[N-1:0]) begin
      miscompares++;
      $display("FAIL post_wrap: seq_count=%0d active=%h, required 1/%h", seq_count, elec_active, f[N-1:0]);
    end
    for (int i = 0; i < 40; i++) begin
      serial_in = 1'($urandom_range(0, 1));
      enable_config = 1'b1;
      tick(1);
    end
    rst = 1'b1;
    tick(1);
    vectors++;
    if ({elec_active, cfg_pending, frame_ok, frame_err, seq_miss, applied, seq_count, halted} !== '0) begin
      miscompares++;
      $display("FAIL midframe_reset: active=%h pend=%b ok=%b err=%b miss=%b app=%b cnt=%0d halt=%b, required all 0",
               elec_active, cfg_pending, frame_ok, frame_err, seq_miss, applied, seq_count, halted);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_length();
    test_seq_miss();
    test_halt();
    test_simultaneous();
    test_wrap_and_reset();
    tick(4);
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expected applies outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
